// File: rtl/full_adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
package full_adder_pkg;

  localparam int FA_WIDTH_DEFAULT = 1;
  localparam int FA_WIDTH_MAX     = 64;

endpackage : full_adder_pkg

// File: rtl/full_adder_fa_cell.sv
// One-bit combinational full-adder cell; chained by full_adder into a ripple carry.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);

endmodule : fa_cell

// File: rtl/full_adder.sv
// Registered WIDTH-bit adder: {cout,sum} = a + b + c, one-cycle latency, one result per clock.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  if (WIDTH < 1 || WIDTH > FA_WIDTH_MAX) begin : g_bad_width
    $error("full_adder: WIDTH=%0d outside 1..%0d", WIDTH, FA_WIDTH_MAX);
  end

  // Operands are forced to zero when idle so undriven/unknown inputs never reach the chain.
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  assign w_a        = a & {WIDTH{in_valid}};
  assign w_b        = b & {WIDTH{in_valid}};
  assign w_carry[0] = c & in_valid;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_cell u_cell (
      .a   (w_a[i]),
      .b   (w_b[i]),
      .cin (w_carry[i]),
      .s   (w_sum[i]),
      .co  (w_carry[i+1])
    );
  end

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_out_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_carry[WIDTH];
      end
    end
  end

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign out_valid = r_out_valid;

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH=1, 8 and 16 sharing one clock and reset.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst_n;

  logic        a1, b1, c1, v1;
  logic        s1, co1, ov1;
  logic [7:0]  a8, b8, s8;
  logic        c8, v8, co8, ov8;
  logic [15:0] a16, b16, s16;
  logic        c16, v16, co16, ov16;

  logic [16:0] q1[$];
  logic [16:0] q8[$];
  logic [16:0] q16[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .in_valid(v1),
    .sum(s1), .cout(co1), .out_valid(ov1)
  );
  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8), .in_valid(v8),
    .sum(s8), .cout(co8), .out_valid(ov8)
  );
  full_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .c(c16), .in_valid(v16),
    .sum(s16), .cout(co16), .out_valid(ov16)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected result %0h with empty scoreboard", nm, act);
  endtask

  // Monitors: pop one expected result each time a DUT flags out_valid.
  always @(negedge clk) begin
    if (ov1 === 1'b1) begin
      if (q1.size() == 0) unexpected("w1_result", {co1, s1});
      else chk("w1_result", 64'({co1, s1}), 64'(q1.pop_front()));
    end
    if (ov8 === 1'b1) begin
      if (q8.size() == 0) unexpected("w8_result", {co8, s8});
      else chk("w8_result", 64'({co8, s8}), 64'(q8.pop_front()));
    end
    if (ov16 === 1'b1) begin
      if (q16.size() == 0) unexpected("w16_result", {co16, s16});
      else chk("w16_result", 64'({co16, s16}), 64'(q16.pop_front()));
    end
  end

  // Inputs change just after the falling edge, after the monitors have sampled.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  logic [1:0] exh_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    rst_n = 1'b0;
    {a1, b1, c1, v1} = '0;
    {a8, b8, c8, v8} = '0;
    {a16, b16, c16, v16} = '0;
    @(negedge clk); #1;
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    tick();
    v8 = 1'b0;
    tick();
    chk("reset_w8", 64'({ov8, co8, s8}), 64'h0);
    chk("reset_w16", 64'({ov16, co16, s16}), 64'h0);
    chk("reset_w1", 64'({ov1, co1, s1}), 64'h0);
    rst_n = 1'b1;

    // WIDTH=1 exhaustive truth table, back-to-back
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = 3'(i);
      v1 = 1'b1;
      q1.push_back(17'(exh_exp[i]));
      tick();
    end
    v1 = 1'b0;
    tick();
    chk("w1_valid_drop", 64'(ov1), 64'h0);

    // WIDTH=8 overflow / zero-sum boundaries, back-to-back
    v8 = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; q8.push_back(17'h1FF); tick();
    a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; q8.push_back(17'h100); tick();
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b0; q8.push_back(17'h046); tick();
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0; q8.push_back(17'h000); tick();
    a8 = 8'h01; b8 = 8'h02; c8 = 1'b0; q8.push_back(17'h003); tick();
    // Hold: idle cycles with new operand values must not disturb the result
    v8 = 1'b0; a8 = 8'hAA; b8 = 8'h55; c8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("w8_hold", 64'({ov8, co8, s8}), 64'h003);
    end
    a8 = 'x; b8 = 'x; c8 = 1'bx;
    tick();
    chk("w8_hold_x", 64'({ov8, co8, s8}), 64'h003);
    a8 = '0; b8 = '0; c8 = 1'b0;

    // WIDTH=16 reset in the middle of a valid stream
    v16 = 1'b1;
    a16 = 16'hFFFF; b16 = 16'h0001; c16 = 1'b0; q16.push_back(17'h10000); tick();
    a16 = 16'h1234; b16 = 16'h4321; c16 = 1'b1; q16.push_back(17'h05556); tick();
    a16 = 16'h8000; b16 = 16'h8000; c16 = 1'b1; q16.push_back(17'h10001); tick();
    rst_n = 1'b0;
    a16 = 16'h7777; b16 = 16'h1111; c16 = 1'b0;
    tick();
    chk("w16_midreset", 64'({ov16, co16, s16}), 64'h0);
    rst_n = 1'b1;
    a16 = 16'h00FF; b16 = 16'h0F0F; c16 = 1'b1; q16.push_back(17'h0100F); tick();
    a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1; q16.push_back(17'h1FFFF); tick();

    // WIDTH=16 random stream checked against a+b+c
    for (int i = 0; i < 10000; i++) begin
      v16 = 1'($urandom_range(1, 0));
      a16 = 16'($urandom());
      b16 = 16'($urandom());
      c16 = 1'($urandom_range(1, 0));
      if (v16) q16.push_back(17'(a16) + 17'(b16) + 17'(c16));
      tick();
    end
    v16 = 1'b0;
    tick();
    tick();

    chk("w1_drain", 64'(q1.size()), 64'h0);
    chk("w8_drain", 64'(q8.size()), 64'h0);
    chk("w16_drain", 64'(q16.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_full_adder
